// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// Stall lengths are expressed in pipeline cycles.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] STALL_LOAD_USE = 2'd1;
  localparam logic [1:0] STALL_BR_ALU   = 2'd1;
  localparam logic [1:0] STALL_BR_LOAD  = 2'd2;

endpackage

// File: rtl/hazard_compare.sv
// Combinational dependence check between the ID instruction and the EX instruction.
// Produces the number of stall cycles needed before ID may proceed.
module hazard_compare
  import hazard_pkg::*;
(
  input  logic [4:0] IDRs,
  input  logic [4:0] IDRt,
  input  logic       IDUsesRt,
  input  logic       IDBranch,
  input  logic [4:0] EXEDest,
  input  logic       EXERegWrite,
  input  logic       EXEMemRead,
  output logic [1:0] stallLen
);

  logic matchRs;
  logic matchRt;
  logic match;

  // $zero is never a real producer, so it can never create a dependence
  assign matchRs = (EXEDest != REG_ZERO) && (EXEDest == IDRs);
  assign matchRt = (EXEDest != REG_ZERO) && IDUsesRt && (EXEDest == IDRt);
  assign match   = matchRs || matchRt;

  always_comb begin
    stallLen = 2'd0;
    if (match) begin
      if (IDBranch && EXEMemRead) begin
        stallLen = STALL_BR_LOAD;
      end else if (IDBranch && EXERegWrite) begin
        stallLen = STALL_BR_ALU;
      end else if (!IDBranch && EXEMemRead) begin
        stallLen = STALL_LOAD_USE;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush / freeze controller for the 5-stage MIPS pipeline.
// Memory wait states freeze the whole pipeline and take priority over ID-stage stalls.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IDRs,
  input  logic [4:0] IDRt,
  input  logic       IDUsesRt,
  input  logic       IDBranch,
  input  logic       branchTaken,
  input  logic [4:0] EXEDest,
  input  logic       EXERegWrite,
  input  logic       EXEMemRead,
  input  logic       MEMMemAccess,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       freeze,
  output logic       memTimeout
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  state_t         state_reg, state_next;
  state_t         ret_state_reg, ret_state_next;
  state_t         eff_state;
  logic [1:0]     stall_cnt_reg, stall_cnt_next;
  logic [1:0]     stall_len;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           mem_timeout_reg, mem_timeout_next;
  logic           mem_wait;

  hazard_compare u_compare (
    .IDRs       (IDRs),
    .IDRt       (IDRt),
    .IDUsesRt   (IDUsesRt),
    .IDBranch   (IDBranch),
    .EXEDest    (EXEDest),
    .EXERegWrite(EXERegWrite),
    .EXEMemRead (EXEMemRead),
    .stallLen   (stall_len)
  );

  assign mem_wait = MEMMemAccess && !memReady;
  // The cycle memory finally answers behaves like the interrupted state,
  // so a frozen stall sequence resumes exactly where it left off.
  assign eff_state = (state_reg == MEM_WAIT) ? ret_state_reg : state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      ret_state_reg   <= RUN;
      stall_cnt_reg   <= 2'd0;
      wait_cnt_reg    <= '0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_state_reg   <= ret_state_next;
      stall_cnt_reg   <= stall_cnt_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ret_state_next   = ret_state_reg;
    stall_cnt_next   = stall_cnt_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    pcWrite          = 1'b1;
    IFIDWrite        = 1'b1;
    IFIDFlush        = 1'b0;
    IDEXBubble       = 1'b0;
    freeze           = 1'b0;

    if (mem_wait) begin
      freeze    = 1'b1;
      pcWrite   = 1'b0;
      IFIDWrite = 1'b0;
      if (state_reg != MEM_WAIT) begin
        ret_state_next = state_reg;
        state_next     = MEM_WAIT;
      end
      if (wait_cnt_reg < WAIT_MAX) begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
      end
      if (wait_cnt_next == WAIT_MAX) begin
        mem_timeout_next = 1'b1;
      end
    end else begin
      wait_cnt_next = '0;
      state_next    = RUN;
      case (eff_state)
        STALL: begin
          pcWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXBubble = 1'b1;
          if (stall_cnt_reg > 2'd1) begin
            stall_cnt_next = stall_cnt_reg - 2'd1;
            state_next     = STALL;
          end else begin
            stall_cnt_next = 2'd0;
          end
        end
        default: begin
          if (stall_len != 2'd0) begin
            pcWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            // Single-cycle stalls stay in RUN: the bubble reaching EX clears the match
            if (stall_len > 2'd1) begin
              state_next     = STALL;
              stall_cnt_next = stall_len - 2'd1;
            end
          end else begin
            IFIDFlush = branchTaken;
          end
        end
      endcase
    end

    if (rst) begin
      pcWrite    = 1'b1;
      IFIDWrite  = 1'b1;
      IFIDFlush  = 1'b0;
      IDEXBubble = 1'b0;
      freeze     = 1'b0;
    end
  end

  assign memTimeout = mem_timeout_reg && !rst;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic,
// all compared against a cycle-level model of owed stall cycles and memory waits.
module tb_hazard_unit;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IDRs, IDRt, EXEDest;
  logic       IDUsesRt, IDBranch, branchTaken, EXERegWrite, EXEMemRead;
  logic       MEMMemAccess, memReady;
  logic       pcWrite, IFIDWrite, IFIDFlush, IDEXBubble, freeze, memTimeout;

  int checks = 0;
  int errors = 0;

  // {pcWrite, IFIDWrite, IFIDFlush, IDEXBubble, freeze, memTimeout}
  logic [5:0] obs, exp;

  int m_owed;
  int m_wait;
  bit m_to;

  hazard_unit #(.MEM_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .IDRs        (IDRs),
    .IDRt        (IDRt),
    .IDUsesRt    (IDUsesRt),
    .IDBranch    (IDBranch),
    .branchTaken (branchTaken),
    .EXEDest     (EXEDest),
    .EXERegWrite (EXERegWrite),
    .EXEMemRead  (EXEMemRead),
    .MEMMemAccess(MEMMemAccess),
    .memReady    (memReady),
    .pcWrite     (pcWrite),
    .IFIDWrite   (IFIDWrite),
    .IFIDFlush   (IFIDFlush),
    .IDEXBubble  (IDEXBubble),
    .freeze      (freeze),
    .memTimeout  (memTimeout)
  );

  always #5 clk = ~clk;

  // Stall cycles the current ID/EX pair demands
  function automatic int n_req();
    bit m;
    m = (EXEDest != 0) && ((EXEDest == IDRs) || (IDUsesRt && EXEDest == IDRt));
    if (!m) return 0;
    if (IDBranch && EXEMemRead) return 2;
    if (IDBranch && EXERegWrite) return 1;
    if (!IDBranch && EXEMemRead) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] model_exp();
    if (rst) return 6'b110000;
    if (MEMMemAccess && !memReady) return {5'b00001, m_to};
    if (m_owed > 0 || n_req() > 0) return {5'b00010, m_to};
    return {2'b11, branchTaken, 2'b00, m_to};
  endfunction

  task automatic model_commit();
    if (rst) begin
      m_owed = 0; m_wait = 0; m_to = 0;
    end else if (MEMMemAccess && !memReady) begin
      if (m_wait < T) m_wait++;
      if (m_wait >= T) m_to = 1;
    end else begin
      m_wait = 0;
      if (m_owed > 0) m_owed--;
      else if (n_req() > 0) m_owed = n_req() - 1;
    end
  endtask

  // Advance one cycle: capture expected and observed at the falling edge
  task automatic do_cycle();
    @(negedge clk);
    exp = model_exp();
    obs = {pcWrite, IFIDWrite, IFIDFlush, IDEXBubble, freeze, memTimeout};
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; IDRs = 0; IDRt = 0; IDUsesRt = 0; IDBranch = 0; branchTaken = 0;
    EXEDest = 0; EXERegWrite = 0; EXEMemRead = 0; MEMMemAccess = 0; memReady = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1; MEMMemAccess = 1; memReady = 0; EXEMemRead = 1; EXEDest = 5; IDRs = 5;
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      checks++;
      if (obs !== 6'b110000) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got %b want %b", i, obs, 6'b110000);
      end
    end
    set_idle();
    do_cycle();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_release: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_load_use();
    int bubbles = 0;
    set_idle();
    EXEMemRead = 1; EXEDest = 8; IDRs = 8;
    do_cycle();
    bubbles += int'(obs[2]);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL load_use_stall: got %b want %b", obs, exp);
    end
    EXEMemRead = 0; EXEDest = 0;
    do_cycle();
    bubbles += int'(obs[2]);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL load_use_resume: got %b want %b", obs, exp);
    end
    checks++;
    if (bubbles != 1) begin
      errors++;
      $display("FAIL load_use_len: got %0d want 1", bubbles);
    end
    EXEMemRead = 1; EXEDest = 0; IDRs = 8;
    do_cycle();
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL load_use_zero_dest: got %b want %b", obs, 6'b110000);
    end
  endtask

  task automatic test_branch_load();
    int bubbles = 0;
    int flushes = 0;
    set_idle();
    IDBranch = 1; EXEMemRead = 1; EXEDest = 9; IDRt = 9; IDUsesRt = 1; branchTaken = 1;
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      bubbles += int'(obs[2]);
      flushes += int'(obs[3]);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL br_load_stall cyc%0d: got %b want %b", i, obs, exp);
      end
    end
    checks++;
    if (bubbles != 2 || flushes != 0) begin
      errors++;
      $display("FAIL br_load_len: got bubbles=%0d flushes=%0d want 2/0", bubbles, flushes);
    end
    EXEMemRead = 0; EXEDest = 0;
    do_cycle();
    checks++;
    if (obs !== 6'b111000) begin
      errors++;
      $display("FAIL br_load_flush: got %b want %b", obs, 6'b111000);
    end
    branchTaken = 0; IDBranch = 0;
    do_cycle();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL br_load_after: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_branch_alu();
    int bubbles = 0;
    set_idle();
    EXERegWrite = 1; EXEDest = 3; IDRs = 3; IDBranch = 1;
    do_cycle();
    bubbles += int'(obs[2]);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL br_alu_stall: got %b want %b", obs, exp);
    end
    EXERegWrite = 0; EXEDest = 0;
    do_cycle();
    bubbles += int'(obs[2]);
    checks++;
    if (obs !== exp || bubbles != 1) begin
      errors++;
      $display("FAIL br_alu_resume: got %b bubbles=%0d want %b bubbles=1", obs, bubbles, exp);
    end
  endtask

  task automatic test_freeze_in_stall();
    int bubbles = 0;
    int freezes = 0;
    set_idle();
    IDBranch = 1; EXEMemRead = 1; EXEDest = 9; IDRt = 9; IDUsesRt = 1; branchTaken = 1;
    do_cycle();
    bubbles += int'(obs[2]);
    MEMMemAccess = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      freezes += int'(obs[1]);
      bubbles += int'(obs[2]);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL freeze_stall cyc%0d: got %b want %b", i, obs, exp);
      end
    end
    memReady = 1;
    do_cycle();
    bubbles += int'(obs[2]);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL freeze_resume: got %b want %b", obs, exp);
    end
    checks++;
    if (bubbles != 2 || freezes != 3) begin
      errors++;
      $display("FAIL freeze_counts: got bubbles=%0d freezes=%0d want 2/3", bubbles, freezes);
    end
    MEMMemAccess = 0; EXEMemRead = 0; EXEDest = 0;
    do_cycle();
    checks++;
    if (obs !== 6'b111000) begin
      errors++;
      $display("FAIL freeze_flush: got %b want %b", obs, 6'b111000);
    end
  endtask

  task automatic test_timeout();
    set_idle();
    MEMMemAccess = 1; memReady = 0;
    for (int i = 0; i < 6; i++) begin
      do_cycle();
      checks++;
      if (obs !== exp || obs[0] !== (i >= T)) begin
        errors++;
        $display("FAIL timeout_wait cyc%0d: got %b want %b", i, obs, exp);
      end
    end
    memReady = 1;
    for (int i = 0; i < 2; i++) begin
      do_cycle();
      checks++;
      if (obs[0] !== 1'b1 || obs !== exp) begin
        errors++;
        $display("FAIL timeout_sticky cyc%0d: got %b want %b", i, obs, exp);
      end
    end
    rst = 1;
    do_cycle();
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL timeout_rst: got %b want %b", obs, 6'b110000);
    end
    rst = 0;
    do_cycle();
    checks++;
    if (obs[0] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleared: got %b want 0", obs[0]);
    end
  endtask

  task automatic test_reset_mid_seq();
    set_idle();
    MEMMemAccess = 1; memReady = 0;
    do_cycle();
    do_cycle();
    rst = 1;
    do_cycle();
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL rst_mid_wait: got %b want %b", obs, 6'b110000);
    end
    set_idle();
    do_cycle();
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL rst_wait_after: got %b want %b", obs, 6'b110000);
    end
    IDBranch = 1; EXEMemRead = 1; EXEDest = 9; IDRt = 9; IDUsesRt = 1;
    do_cycle();
    rst = 1;
    do_cycle();
    set_idle();
    do_cycle();
    checks++;
    if (obs !== 6'b110000) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b want %b", obs, 6'b110000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      IDRs         = 5'($urandom_range(0, 3));
      IDRt         = 5'($urandom_range(0, 3));
      EXEDest      = 5'($urandom_range(0, 3));
      IDUsesRt     = 1'($urandom_range(0, 1));
      IDBranch     = 1'($urandom_range(0, 1));
      branchTaken  = 1'($urandom_range(0, 1));
      EXERegWrite  = 1'($urandom_range(0, 1));
      EXEMemRead   = 1'($urandom_range(0, 1));
      MEMMemAccess = ($urandom_range(0, 2) == 0);
      memReady     = 1'($urandom_range(0, 1));
      do_cycle();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    m_owed = 0; m_wait = 0; m_to = 0;
    set_idle();
    rst = 1;
    #1;
    test_reset();
    test_load_use();
    test_branch_load();
    test_branch_alu();
    test_freeze_in_stall();
    test_timeout();
    test_reset_mid_seq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
